// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory slave between the CPU instruction and data ports.
// Each port has a single pending slot; one slave request is outstanding at a time.
// Data has priority, but an instruction request waiting behind starve_limit
// consecutive data grants wins the next issue point.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   imem_valid/instr/addr/wdata/wstrb instruction request (single-cycle pulse)
//   imem_rdata, imem_ready            instruction response
//   dmem_valid/instr/addr/wdata/wstrb data request (single-cycle pulse)
//   dmem_rdata, dmem_ready            data response
//   mem_valid/instr/addr/wdata/wstrb  slave request (pulse, attributes 0 when idle)
//   mem_rdata, mem_ready              slave response
module mem_arbiter #(
    parameter int unsigned starve_limit = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic [7:0] StarveLim = 8'(starve_limit);

    state_e      state_q, state_d;
    logic        i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic        i_instr_q, i_instr_d, d_instr_q, d_instr_d;
    logic [31:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [31:0] i_wdata_q, i_wdata_d, d_wdata_q, d_wdata_d;
    logic [3:0]  i_wstrb_q, i_wstrb_d, d_wstrb_q, d_wstrb_d;
    logic [7:0]  starve_q, starve_d;

    logic        issue, i_cand, d_cand, grant_i, grant_d;
    logic        i_c_instr, d_c_instr;
    logic [31:0] i_c_addr, d_c_addr, i_c_wdata, d_c_wdata;
    logic [3:0]  i_c_wstrb, d_c_wstrb;

    // Candidate per port: the held slot, else a same-cycle arriving pulse.
    always_comb begin
        i_cand    = i_pend_q | imem_valid;
        i_c_instr = i_pend_q ? i_instr_q : imem_instr;
        i_c_addr  = i_pend_q ? i_addr_q  : imem_addr;
        i_c_wdata = i_pend_q ? i_wdata_q : imem_wdata;
        i_c_wstrb = i_pend_q ? i_wstrb_q : imem_wstrb;
        d_cand    = d_pend_q | dmem_valid;
        d_c_instr = d_pend_q ? d_instr_q : dmem_instr;
        d_c_addr  = d_pend_q ? d_addr_q  : dmem_addr;
        d_c_wdata = d_pend_q ? d_wdata_q : dmem_wdata;
        d_c_wstrb = d_pend_q ? d_wstrb_q : dmem_wstrb;
    end

    // A completing transaction frees the slave in the same cycle, so the next
    // request can issue back-to-back.
    always_comb begin
        issue   = (state_q == StIdle) | mem_ready;
        grant_d = issue & d_cand & ~(i_cand & (starve_q == StarveLim));
        grant_i = issue & i_cand & ~grant_d;
    end

    always_comb begin
        state_d   = state_q;
        i_pend_d  = i_pend_q;
        i_instr_d = i_instr_q;
        i_addr_d  = i_addr_q;
        i_wdata_d = i_wdata_q;
        i_wstrb_d = i_wstrb_q;
        d_pend_d  = d_pend_q;
        d_instr_d = d_instr_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_wstrb_d = d_wstrb_q;
        starve_d  = starve_q;

        // A pulse into an occupied slot is dropped; the original is kept.
        if (imem_valid && !i_pend_q) begin
            i_pend_d  = 1'b1;
            i_instr_d = imem_instr;
            i_addr_d  = imem_addr;
            i_wdata_d = imem_wdata;
            i_wstrb_d = imem_wstrb;
        end
        if (dmem_valid && !d_pend_q) begin
            d_pend_d  = 1'b1;
            d_instr_d = dmem_instr;
            d_addr_d  = dmem_addr;
            d_wdata_d = dmem_wdata;
            d_wstrb_d = dmem_wstrb;
        end
        if (grant_i) i_pend_d = 1'b0;
        if (grant_d) d_pend_d = 1'b0;

        if (!i_cand || grant_i) begin
            starve_d = 8'd0;
        end else if (grant_d && starve_q != 8'hFF) begin
            starve_d = starve_q + 8'd1;
        end

        if (issue) begin
            if (grant_d) begin
                state_d = StBusyD;
            end else if (grant_i) begin
                state_d = StBusyI;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        mem_valid = grant_i | grant_d;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (grant_d) begin
            mem_instr = d_c_instr;
            mem_addr  = d_c_addr;
            mem_wdata = d_c_wdata;
            mem_wstrb = d_c_wstrb;
        end else if (grant_i) begin
            mem_instr = i_c_instr;
            mem_addr  = i_c_addr;
            mem_wdata = i_c_wdata;
            mem_wstrb = i_c_wstrb;
        end
        imem_ready = mem_ready & (state_q == StBusyI);
        dmem_ready = mem_ready & (state_q == StBusyD);
        imem_rdata = imem_ready ? mem_rdata : 32'd0;
        dmem_rdata = dmem_ready ? mem_rdata : 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            i_pend_q  <= 1'b0;
            i_instr_q <= 1'b0;
            i_addr_q  <= 32'd0;
            i_wdata_q <= 32'd0;
            i_wstrb_q <= 4'd0;
            d_pend_q  <= 1'b0;
            d_instr_q <= 1'b0;
            d_addr_q  <= 32'd0;
            d_wdata_q <= 32'd0;
            d_wstrb_q <= 4'd0;
            starve_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            i_pend_q  <= i_pend_d;
            i_instr_q <= i_instr_d;
            i_addr_q  <= i_addr_d;
            i_wdata_q <= i_wdata_d;
            i_wstrb_q <= i_wstrb_d;
            d_pend_q  <= d_pend_d;
            d_instr_q <= d_instr_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_wstrb_q <= d_wstrb_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic against a
// slave model with configurable latency. A transaction-level reference model
// predicts slave requests and port responses into queues; a monitor pops and
// compares whenever the DUT presents mem_valid / imem_ready / dmem_ready.
module tb_mem_arbiter;

    localparam int unsigned Limit = 4;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int   stamp;
        req_t r;
    } exp_req_t;

    typedef struct {
        int          stamp;
        logic [31:0] data;
    } exp_rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_valid = 1'b0, imem_instr = 1'b0;
    logic [31:0] imem_addr = '0, imem_wdata = '0;
    logic [3:0]  imem_wstrb = '0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0, dmem_instr = 1'b0;
    logic [31:0] dmem_addr = '0, dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    mem_arbiter #(.starve_limit(Limit)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_req_t exp_mem_q[$];
    exp_rsp_t exp_i_q[$];
    exp_rsp_t exp_d_q[$];

    always @(negedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic miss(input string name, input int stamp);
        checks++;
        errors++;
        $display("FAIL %s cycle %0d: expected event from cycle %0d not seen", name, cyc, stamp);
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.instr = 1'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.wstrb = 4'($urandom);
        return r;
    endfunction

    // ---------------- stimulus + slave model ----------------
    logic stg_rst = 1'b0;
    logic stg_iv = 1'b0, stg_dv = 1'b0;
    req_t stg_ir, stg_dr;
    bit   sl_busy = 0;
    int   sl_cnt = 0;
    int   lat_min = 1, lat_max = 1;

    task automatic tick();
        req_t ri, rd;
        @(negedge clk);
        rst = stg_rst;
        if (sl_busy && sl_cnt == 0) begin
            mem_ready = 1'b1;
            sl_busy   = 0;
        end else begin
            mem_ready = 1'b0;
            if (sl_busy) sl_cnt--;
        end
        mem_rdata = $urandom;
        // Idle cycles carry garbage attributes that must be ignored.
        ri = stg_iv ? stg_ir : rnd_req();
        rd = stg_dv ? stg_dr : rnd_req();
        imem_valid = stg_iv;
        {imem_instr, imem_addr, imem_wdata, imem_wstrb} = ri;
        dmem_valid = stg_dv;
        {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb} = rd;
        stg_iv = 1'b0;
        stg_dv = 1'b0;
        #3;
        if (mem_valid === 1'b1) begin
            sl_busy = 1;
            sl_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
        end
    endtask

    task automatic set_i(input logic [31:0] addr);
        stg_iv       = 1'b1;
        stg_ir       = rnd_req();
        stg_ir.instr = 1'b1;
        stg_ir.addr  = addr;
    endtask

    task automatic set_d(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        stg_dv       = 1'b1;
        stg_dr.instr = 1'b0;
        stg_dr.addr  = addr;
        stg_dr.wdata = wdata;
        stg_dr.wstrb = wstrb;
    endtask

    // ---------------- reference model ----------------
    // Port 0 = instruction, port 1 = data. owner = port whose request is at the slave.
    req_t m_pend[2];
    bit   m_has[2];
    int   m_owner = -1;
    int   m_waits = 0;  // data grants taken while an instruction request waited

    always begin
        bit ok;
        int win;
        @(negedge clk);
        #1;
        if (rst !== 1'b1) begin
            m_has[0] = 0;
            m_has[1] = 0;
            m_owner  = -1;
            m_waits  = 0;
        end else begin
            if (m_owner == 0 && mem_ready) exp_i_q.push_back('{cyc, mem_rdata});
            if (m_owner == 1 && mem_ready) exp_d_q.push_back('{cyc, mem_rdata});
            ok = (m_owner < 0) || mem_ready;
            if (imem_valid && !m_has[0]) begin
                m_has[0]  = 1;
                m_pend[0] = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
            end
            if (dmem_valid && !m_has[1]) begin
                m_has[1]  = 1;
                m_pend[1] = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};
            end
            win = -1;
            if (ok) begin
                if (m_has[1] && !(m_has[0] && m_waits == int'(Limit))) win = 1;
                else if (m_has[0]) win = 0;
            end
            if (!m_has[0] || win == 0) m_waits = 0;
            else if (win == 1 && m_waits < 255) m_waits++;
            if (ok) begin
                if (win >= 0) begin
                    exp_mem_q.push_back('{cyc, m_pend[win]});
                    m_has[win] = 0;
                end
                m_owner = win;
            end
        end
    end

    // ---------------- monitor ----------------
    always begin
        exp_req_t er;
        exp_rsp_t ep;
        @(negedge clk);
        #2;
        if (mem_valid === 1'b1) begin
            if (exp_mem_q.size() == 0) begin
                chk("mem_valid_unexpected", 69'(mem_valid), 69'(0));
            end else begin
                er = exp_mem_q.pop_front();
                chk("mem_issue_cycle", 69'(cyc), 69'(er.stamp));
                chk("mem_req_fields", {mem_instr, mem_addr, mem_wdata, mem_wstrb}, er.r);
            end
        end else begin
            chk("mem_attr_idle_zero", {mem_instr, mem_addr, mem_wdata, mem_wstrb}, 69'(0));
        end
        while (exp_mem_q.size() > 0 && exp_mem_q[0].stamp <= cyc) begin
            miss("mem_valid_missing", exp_mem_q[0].stamp);
            void'(exp_mem_q.pop_front());
        end

        if (imem_ready === 1'b1) begin
            if (exp_i_q.size() == 0) begin
                chk("imem_ready_unexpected", 69'(imem_ready), 69'(0));
            end else begin
                ep = exp_i_q.pop_front();
                chk("imem_ready_cycle", 69'(cyc), 69'(ep.stamp));
                chk("imem_rdata", 69'(imem_rdata), 69'(ep.data));
            end
        end else begin
            chk("imem_rdata_idle_zero", 69'(imem_rdata), 69'(0));
        end
        while (exp_i_q.size() > 0 && exp_i_q[0].stamp <= cyc) begin
            miss("imem_ready_missing", exp_i_q[0].stamp);
            void'(exp_i_q.pop_front());
        end

        if (dmem_ready === 1'b1) begin
            if (exp_d_q.size() == 0) begin
                chk("dmem_ready_unexpected", 69'(dmem_ready), 69'(0));
            end else begin
                ep = exp_d_q.pop_front();
                chk("dmem_ready_cycle", 69'(cyc), 69'(ep.stamp));
                chk("dmem_rdata", 69'(dmem_rdata), 69'(ep.data));
            end
        end else begin
            chk("dmem_rdata_idle_zero", 69'(dmem_rdata), 69'(0));
        end
        while (exp_d_q.size() > 0 && exp_d_q[0].stamp <= cyc) begin
            miss("dmem_ready_missing", exp_d_q[0].stamp);
            void'(exp_d_q.pop_front());
        end
    end

    // ---------------- scenarios ----------------
    task automatic random_phase(input int n, input int p_i, input int p_d,
                                input int lmin, input int lmax);
        lat_min = lmin;
        lat_max = lmax;
        for (int k = 0; k < n; k++) begin
            if (int'($urandom_range(99)) < p_i) set_i($urandom);
            if (int'($urandom_range(99)) < p_d) set_d($urandom, $urandom, 4'($urandom));
            tick();
        end
    endtask

    initial begin
        stg_ir = '0;
        stg_dr = '0;
        stg_rst = 1'b0;
        repeat (3) tick();
        stg_rst = 1'b1;
        repeat (2) tick();

        // Lone requests against a 1-cycle slave.
        lat_min = 1;
        lat_max = 1;
        set_i(32'h100);
        tick();
        repeat (3) tick();
        set_d(32'h200, 32'hDEADBEEF, 4'hF);
        tick();
        repeat (3) tick();

        // Simultaneous pulses: data first, instruction back-to-back.
        set_i(32'h300);
        set_d(32'h400, 32'h1234_5678, 4'h3);
        tick();
        repeat (4) tick();

        // Starvation: instruction waits while data pulses on every ready.
        for (int k = 0; k < 10; k++) begin
            if (k == 0) set_i(32'h500);
            set_d(32'h600 + 32'(k * 4), $urandom, 4'hF);
            tick();
        end
        repeat (4) tick();

        // Slave wait states with an instruction pulse during the wait.
        lat_min = 5;
        lat_max = 5;
        set_d(32'h680, 32'h0, 4'h0);
        tick();
        tick();
        set_i(32'h6C0);
        tick();
        repeat (12) tick();

        // Second data pulse into an occupied slot is ignored.
        set_i(32'h700);
        tick();
        set_d(32'h800, 32'hAAAA_5555, 4'h1);
        tick();
        set_d(32'h900, 32'h5555_AAAA, 4'h2);
        tick();
        repeat (16) tick();

        // Reset mid-busy; the slave's late ready must not be forwarded.
        set_d(32'hA00, 32'h0, 4'hF);
        tick();
        tick();
        stg_rst = 1'b0;
        tick();
        stg_rst = 1'b1;
        repeat (8) tick();

        random_phase(3000, 30, 50, 1, 4);
        random_phase(1500, 40, 90, 1, 1);
        random_phase(1500, 60, 60, 1, 6);
        lat_min = 1;
        lat_max = 1;
        repeat (12) tick();

        if (exp_mem_q.size() != 0) miss("mem_queue_drain", exp_mem_q[0].stamp);
        if (exp_i_q.size() != 0) miss("imem_queue_drain", exp_i_q[0].stamp);
        if (exp_d_q.size() != 0) miss("dmem_queue_drain", exp_d_q[0].stamp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
